// File: rtl/wb_regfile_pkg.sv
// ============================================================================
// wb_regfile_pkg : shared register-file types and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_regfile_pkg;

   localparam int RegBusW     = 32;
   localparam int RegAddrBusW = 5;
   localparam int RegNum      = 32;

   typedef logic [RegBusW-1:0]     RegBus;
   typedef logic [RegAddrBusW-1:0] RegAddrBus;

   localparam RegBus     ZeroWord     = '0;
   localparam RegAddrBus NOPRegAddr   = '0;
   localparam logic      WriteEnable  = 1'b1;
   localparam logic      WriteDisable = 1'b0;
   localparam logic      ReadEnable   = 1'b1;
   localparam logic      ReadDisable  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/wb_regfile_hilo_reg.sv
// ============================================================================
// wb_regfile_hilo_reg : HI/LO storage with write-through bypass to EX
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_regfile_hilo_reg
   import wb_regfile_pkg::*;
#(
   parameter int DATA_W = RegBusW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_whilo,
   input  logic [DATA_W-1:0] wb_hi,
   input  logic [DATA_W-1:0] wb_lo,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   logic [DATA_W-1:0] hi_q, lo_q;
   logic [DATA_W-1:0] hi_d, lo_d;

   // The next-state value doubles as the bypassed output.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (wb_whilo == WriteEnable) begin
         hi_d = wb_hi;
         lo_d = wb_lo;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign hi_o = rst ? hi_d : '0;
   assign lo_o = rst ? lo_d : '0;

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
// wb_regfile : write-back GPR file (r0 = 0) with bypassed read ports and HI/LO
// Optional commit trace outputs under WB_COMMIT_TRACE_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int DATA_W  = RegBusW,
   parameter int ADDR_W  = RegAddrBusW,
   parameter int REG_NUM = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] wb_wd,
   input  logic              wb_wreg,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic [DATA_W-1:0] wb_hi,
   input  logic [DATA_W-1:0] wb_lo,
   input  logic              wb_whilo,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
`ifdef WB_COMMIT_TRACE_EN
   ,
   output logic [31:0]       commit_cnt,
   output logic              trace_valid,
   output logic [ADDR_W-1:0] trace_wd
`endif
);

   logic [DATA_W-1:0] gpr_q [REG_NUM];
   logic              w_gpr_we;

   assign w_gpr_we = (wb_wreg == WriteEnable) && (wb_wd != ADDR_W'(NOPRegAddr));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            gpr_q[i] <= '0;
         end
      end else if (w_gpr_we) begin
         gpr_q[wb_wd] <= wb_wdata;
      end
   end

   // Bypass is only taken for nonzero addresses, so r0 can never leak wb_wdata.
   always_comb begin
      rdata1 = '0;
      if (rst && (re1 == ReadEnable) && (raddr1 != '0)) begin
         if (w_gpr_we && (raddr1 == wb_wd)) rdata1 = wb_wdata;
         else                               rdata1 = gpr_q[raddr1];
      end
   end

   always_comb begin
      rdata2 = '0;
      if (rst && (re2 == ReadEnable) && (raddr2 != '0)) begin
         if (w_gpr_we && (raddr2 == wb_wd)) rdata2 = wb_wdata;
         else                               rdata2 = gpr_q[raddr2];
      end
   end

   wb_regfile_hilo_reg #(
      .DATA_W (DATA_W)
   ) u_hilo (
      .clk      (clk),
      .rst      (rst),
      .wb_whilo (wb_whilo),
      .wb_hi    (wb_hi),
      .wb_lo    (wb_lo),
      .hi_o     (hi_o),
      .lo_o     (lo_o)
   );

`ifdef WB_COMMIT_TRACE_EN
   logic              w_commit;
   logic [31:0]       commit_cnt_q, commit_cnt_d;
   logic              trace_valid_q;
   logic [ADDR_W-1:0] trace_wd_q;

   // One increment per edge even when GPR and HI/LO both commit.
   assign w_commit     = w_gpr_we || (wb_whilo == WriteEnable);
   assign commit_cnt_d = w_commit ? commit_cnt_q + 32'd1 : commit_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         commit_cnt_q  <= '0;
         trace_valid_q <= WriteDisable;
         trace_wd_q    <= '0;
      end else begin
         commit_cnt_q  <= commit_cnt_d;
         trace_valid_q <= w_commit;
         trace_wd_q    <= wb_wd;
      end
   end

   assign commit_cnt  = commit_cnt_q;
   assign trace_valid = trace_valid_q;
   assign trace_wd    = trace_wd_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// tb_wb_regfile : directed + randomized self-checking bench for wb_regfile
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_regfile;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] wb_wd, raddr1, raddr2;
   logic          wb_wreg, wb_whilo, re1, re2;
   logic [DW-1:0] wb_wdata, wb_hi, wb_lo;
   logic [DW-1:0] rdata1, rdata2, hi_o, lo_o;
`ifdef WB_COMMIT_TRACE_EN
   logic [31:0]   commit_cnt;
   logic          trace_valid;
   logic [AW-1:0] trace_wd;
`endif

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk      (clk),
      .rst      (rst),
      .wb_wd    (wb_wd),
      .wb_wreg  (wb_wreg),
      .wb_wdata (wb_wdata),
      .wb_hi    (wb_hi),
      .wb_lo    (wb_lo),
      .wb_whilo (wb_whilo),
      .re1      (re1),
      .raddr1   (raddr1),
      .rdata1   (rdata1),
      .re2      (re2),
      .raddr2   (raddr2),
      .rdata2   (rdata2),
      .hi_o     (hi_o),
      .lo_o     (lo_o)
`ifdef WB_COMMIT_TRACE_EN
      ,
      .commit_cnt  (commit_cnt),
      .trace_valid (trace_valid),
      .trace_wd    (trace_wd)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;

   // Architectural reference state
   logic [DW-1:0] m_gpr [32];
   logic [DW-1:0] m_hi, m_lo;
   logic [31:0]   m_cnt;
   logic          m_tv;
   logic [AW-1:0] m_twd;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
      m_hi  = '0;
      m_lo  = '0;
      m_cnt = '0;
      m_tv  = 1'b0;
      m_twd = '0;
   endtask

   function automatic logic [DW-1:0] exp_read(input logic re, input logic [AW-1:0] a);
      if (!rst || !re || a == 0) return '0;
      if (wb_wreg && wb_wd == a) return wb_wdata;
      return m_gpr[a];
   endfunction

   function automatic logic [DW-1:0] exp_hi();
      if (!rst) return '0;
      return wb_whilo ? wb_hi : m_hi;
   endfunction

   function automatic logic [DW-1:0] exp_lo();
      if (!rst) return '0;
      return wb_whilo ? wb_lo : m_lo;
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".rdata1"}, rdata1, exp_read(re1, raddr1));
      check({tag, ".rdata2"}, rdata2, exp_read(re2, raddr2));
      check({tag, ".hi_o"},   hi_o,   exp_hi());
      check({tag, ".lo_o"},   lo_o,   exp_lo());
   endtask

   // Clock one edge, commit inputs to the model, then settle.
   task automatic edge_commit();
      logic commit;
      @(posedge clk);
      commit = (wb_wreg && wb_wd != 0) || wb_whilo;
      if (commit) m_cnt = m_cnt + 32'd1;
      m_tv  = commit;
      m_twd = wb_wd;
      if (wb_wreg && wb_wd != 0) m_gpr[wb_wd] = wb_wdata;
      if (wb_whilo) begin
         m_hi = wb_hi;
         m_lo = wb_lo;
      end
      #1;
`ifdef WB_COMMIT_TRACE_EN
      check("commit_cnt",  commit_cnt,       m_cnt);
      check("trace_valid", DW'(trace_valid), DW'(m_tv));
      check("trace_wd",    DW'(trace_wd),    DW'(m_twd));
`endif
   endtask

   task automatic idle_inputs();
      wb_wd = '0; wb_wreg = 1'b0; wb_wdata = '0;
      wb_hi = '0; wb_lo = '0; wb_whilo = 1'b0;
      re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
   endtask

   initial begin
      idle_inputs();
      model_reset();
      rst = 1'b0;
      // Outputs gated during reset even with a live bypass on the inputs
      wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hFFFF_0000; wb_whilo = 1'b1; wb_hi = 32'h1;
      re1 = 1'b1; raddr1 = 5'd5;
      #2;
      check("in_reset.rdata1", rdata1, 32'h0);
      check("in_reset.hi_o",   hi_o,   32'h0);
      repeat (2) @(posedge clk);
      #1;
      idle_inputs();
      rst = 1'b1;

      // Reset then read
      re1 = 1'b1; raddr1 = 5'd5;
      #1;
      check("reset_read.rdata1", rdata1, 32'h0);
      check("reset_read.hi_o",   hi_o,   32'h0);
      check("reset_read.lo_o",   lo_o,   32'h0);

      // Write / read
      wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h1234_5678;
      edge_commit();
      wb_wreg = 1'b0; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd4;
      #1;
      check("wr.rdata1", rdata1, 32'h1234_5678);
      check("wr.rdata2", rdata2, 32'h0);

      // Same-cycle bypass on both ports
      wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'hDEAD_BEEF; raddr1 = 5'd7; raddr2 = 5'd7;
      #1;
      check("byp.rdata1", rdata1, 32'hDEAD_BEEF);
      check("byp.rdata2", rdata2, 32'hDEAD_BEEF);
      edge_commit();
      wb_wreg = 1'b0; wb_wdata = '0;
      #1;
      check("byp_stored.rdata1", rdata1, 32'hDEAD_BEEF);
      check("byp_stored.rdata2", rdata2, 32'hDEAD_BEEF);

      // r0 protection
      wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd3;
      #1;
      check("r0_byp.rdata1", rdata1, 32'h0);
      check("r0_byp.rdata2", rdata2, 32'h1234_5678);
      edge_commit();
      wb_wreg = 1'b0;
      #1;
      check("r0_stored.rdata1", rdata1, 32'h0);

      // HI/LO write then hold
      wb_whilo = 1'b1; wb_hi = 32'hA; wb_lo = 32'hB;
      #1;
      check("hilo_byp.hi_o", hi_o, 32'hA);
      check("hilo_byp.lo_o", lo_o, 32'hB);
      edge_commit();
      wb_whilo = 1'b0; wb_hi = 32'hC; wb_lo = 32'hD;
      #1;
      check("hilo_hold.hi_o", hi_o, 32'hA);
      check("hilo_hold.lo_o", lo_o, 32'hB);

      // Reset asserted half a cycle before a write edge
      wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'h55; wb_whilo = 1'b1; wb_hi = 32'h77;
      raddr1 = 5'd9;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      check("rst_mid.rdata1", rdata1, 32'h0);
      check("rst_mid.hi_o",   hi_o,   32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      wb_wreg = 1'b0; wb_whilo = 1'b0;
      #1;
      check("rst_after.rdata1", rdata1, 32'h0);
      check("rst_after.hi_o",   hi_o,   32'h0);
      raddr2 = 5'd7;
      #1;
      check("rst_after.rdata2", rdata2, 32'h0);
`ifdef WB_COMMIT_TRACE_EN
      check("rst_after.commit_cnt", commit_cnt, 32'h0);
`endif

      // Randomized traffic, addresses biased to a small window for frequent hits
      for (int n = 0; n < 300; n++) begin
         wb_wreg  = ($urandom_range(0, 3) != 0);
         wb_wd    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         wb_wdata = $urandom;
         wb_whilo = ($urandom_range(0, 3) == 0);
         wb_hi    = $urandom;
         wb_lo    = $urandom;
         re1      = ($urandom_range(0, 4) != 0);
         re2      = ($urandom_range(0, 4) != 0);
         raddr1   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         raddr2   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) begin
            wb_wreg = 1'b0; wb_wd = '0; wb_whilo = 1'b0;
         end
         #1;
         check_all("rand");
         edge_commit();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back consumer of the MEM/WB pipeline register: takes the wb_* outputs and commits them to architectural state.
- Holds the 32x32 GPR file, with r0 hardwired to zero, plus the HI/LO pair.
- Serves two combinational GPR read ports to ID and the HI/LO values to EX.
- Write-through bypass, so a WB write and an ID read in the same cycle see the new value.

Parameters:
- DATA_W, 32, width of GPR/HI/LO data
- ADDR_W, 5, GPR address width
- REG_NUM, 32, number of GPRs (2**ADDR_W)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wb_wd  in  ADDR_W  GPR write address from MEM/WB
- wb_wreg  in  1  GPR write enable
- wb_wdata  in  DATA_W  GPR write data
- wb_hi  in  DATA_W  HI write data
- wb_lo  in  DATA_W  LO write data
- wb_whilo  in  1  HI/LO write enable (writes both)
- re1  in  1  read enable, port 1
- raddr1  in  ADDR_W  read address, port 1
- rdata1  out  DATA_W  read data, port 1
- re2  in  1  read enable, port 2
- raddr2  in  ADDR_W  read address, port 2
- rdata2  out  DATA_W  read data, port 2
- hi_o  out  DATA_W  current HI (bypassed)
- lo_o  out  DATA_W  current LO (bypassed)

Behaviour:
- Reset (rst=0, asynchronous): all GPRs, HI and LO clear to 0. While rst=0, rdata1/2, hi_o and lo_o are 0 regardless of inputs.
- GPR write: on posedge clk with rst=1, if wb_wreg=1 and wb_wd!=0, the selected GPR takes wb_wdata. Writes to address 0 are silently dropped.
- HI/LO write: on posedge clk with rst=1, if wb_whilo=1, HI takes wb_hi and LO takes wb_lo in the same edge.
- Read priority per port (combinational, zero-cycle latency):
  - re=0 -> 0
  - raddr=0 -> 0
  - wb_wreg=1 and raddr==wb_wd -> wb_wdata (bypass)
  - otherwise -> stored GPR
- Both read ports may hit the same address, including the write address; both return the bypassed value.
- hi_o/lo_o: if wb_whilo=1, output wb_hi/wb_lo; else the stored HI/LO.
- A NOP bubble from MEM/WB (wb_wreg=0, wb_wd=0, wb_whilo=0) changes no state.
- Reset asserted mid-write: reset wins; the write edge is lost and all state reads 0 after release.
- No stall input. MEM/WB already turns a stall into a bubble, so this block commits every cycle.

Optional Feature:
- Macro WB_COMMIT_TRACE_EN.
- When defined, adds three outputs:
  - commit_cnt[31:0]: counts edges with a GPR write to a nonzero address or a HI/LO write. Increments once per edge even if both occur. Wraps 0xFFFFFFFF -> 0. Cleared by rst.
  - trace_valid[1]: registered copy of that commit condition, one cycle after the edge.
  - trace_wd[ADDR_W]: registered copy of wb_wd, one cycle after the edge.
- When undefined, these ports and the counter do not exist, and there is no behavioural difference otherwise.

Decomposition:
- Shared defines package: RegBus, RegAddrBus, ZeroWord, WriteEnable/WriteDisable, ReadEnable/ReadDisable, NOPRegAddr, RegNum.
- One natural sub-module, hilo_reg: the HI/LO storage plus its bypass mux. The GPR array and read ports stay in the top.

Test Plan:
- Reset then read: pulse rst low, release; re1=1, raddr1=5 -> rdata1=0; hi_o=lo_o=0.
- Write/read: wb_wreg=1, wb_wd=3, wb_wdata=0x1234_5678, clock once, drop wb_wreg; raddr1=3 -> 0x12345678; raddr2=4 -> 0.
- Bypass: wb_wreg=1, wb_wd=7, wb_wdata=0xDEADBEEF with raddr1=raddr2=7 in the same cycle -> both ports 0xDEADBEEF before the edge and the stored value after.
- r0 protection: write 0xFFFF_FFFF to wd=0 -> raddr1=0 reads 0, including during the bypass cycle.
- HI/LO: wb_whilo=1, hi=0xA, lo=0xB -> hi_o/lo_o =0xA/0xB combinationally and after the edge. Then whilo=0 with hi=0xC -> hi_o stays 0xA.
- Async reset mid-write: assert rst=0 half-cycle before an edge carrying wd=9, data=0x55 -> after release raddr1=9 reads 0. With WB_COMMIT_TRACE_EN, commit_cnt=0.
